rf_op_sequencer: RTL and testbench
==================================

Name: rf_op_sequencer

Overview:
- Command-driven execution stage that sits directly upstream of the team's 3-read/1-write register file.
- Accepts one register-to-register command per valid/ready handshake and reads the two source operands through the file's read ports 0 and 1.
- Computes a 4-bit-opcode-free ALU result (3-bit opcode) and writes it back through the file's single write port.
- Read port 2 is not driven by this block; it stays free for display/debug logic.

Parameters:
- M, 3: address MSB; register address width is M+1 and the file holds 2^(M+1) entries.
- N, 3: data MSB; data width is N+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  opcode.
- cmd_dst  in  M+1  destination register.
- cmd_src0  in  M+1  source register 0.
- cmd_src1  in  M+1  source register 1.
- cmd_imm  in  N+1  immediate, used by LDI only.
- rf_ra0  out  M+1  to register file ra0.
- rf_ra1  out  M+1  to register file ra1.
- rf_rd0  in  N+1  from register file rd0 (combinational read).
- rf_rd1  in  N+1  from register file rd1.
- rf_wa  out  M+1  to register file wa.
- rf_wd  out  N+1  to register file wd.
- rf_we  out  1  to register file we.
- done  out  1  one-cycle completion pulse.
- result  out  N+1  last computed result.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: synchronous, active-low. On a rising edge with rst_n=0:
  - state goes to IDLE;
  - rf_we, done, result, flag_z, flag_c, rf_wa, rf_wd, rf_ra0 and rf_ra1 all go to 0;
  - any in-flight command is dropped with no write.
  - rf_we is 0 in the cycle following any reset edge.
- Opcodes: 0 NOP, 1 MOV (src0), 2 LDI (imm), 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE -> READ on cmd_valid && cmd_ready. op/dst/src0/src1/imm are latched at this edge; later changes on cmd_* are ignored.
  - READ: rf_ra0/rf_ra1 hold the latched src0/src1. At the end of READ, rf_rd0/rf_rd1 are captured into operand registers. READ -> EXEC.
  - EXEC: ALU result and flags are computed from the operand registers. rf_wa, rf_wd and rf_we (=op!=NOP) are registered at the end of EXEC. EXEC -> WB.
  - WB: rf_we is high for exactly this one cycle (low for NOP), so the file commits at the end of WB. done=1 for this cycle. result/flags update at the end of EXEC for non-NOP ops; NOP leaves result and flags unchanged. WB -> IDLE.
- cmd_ready = (state==IDLE), and cmd_ready does not depend on cmd_valid.
- Throughput is 1 command per 4 cycles. Latency from the accept edge to the write commit is 3 edges.
- Hazards: a write commits before the next command's READ, so no forwarding is needed. dst equal to a source is legal and reads the pre-write value.
- Arithmetic (width N+1):
  - ADD: result wraps modulo 2^(N+1); C = carry out.
  - SUB: result = src0 - src1 modulo 2^(N+1); C = 1 iff src0 < src1 (borrow).
  - MOV, LDI, AND, OR, XOR: C = 0.
  - Z = (result == 0) for every writing op.
- Register 0 is an ordinary register; it is not hardwired to zero.
- rf_ra0/rf_ra1 hold their last values outside READ. rf_wa/rf_wd hold their last values when rf_we=0.

Decomposition:
- Package rf_seq_pkg holds:
  - the opcode localparams (OP_NOP..OP_XOR);
  - the FSM state encoding (2-bit: IDLE=0, READ=1, EXEC=2, WB=3).
- Sub-module rf_seq_alu:
  - purely combinational, parameter N;
  - inputs: op, a, b, imm;
  - outputs: y, c, z, wr_en;
  - instantiated once in EXEC.

Test Plan (M=3, N=3, bench includes a behavioural copy of the register file):
1. Reset, then LDI r1=9, LDI r2=8, ADD r3=r1+r2 -> r3=1, C=1, Z=0. done pulses once per command, 4 cycles apart.
2. SUB r4=r2-r1 (8-9) -> r4=15, C=1. SUB r5=r1-r2 -> r5=1, C=0.
3. XOR r6=r1^r1 -> r6=0, Z=1, C=0. A following NOP -> no rf_we, done=1, flags still Z=1.
4. dst=src: ADD r1=r1+r1 with r1=9 -> r1=2, C=1. A follow-up MOV r7=r1 reads 2 (no hazard).
5. Handshake: cmd_valid held high with changing fields during busy -> only fields present at the IDLE accept edge execute. cmd_ready stays low for 3 cycles after each accept.
6. rst_n=0 for one edge while in EXEC of ADD r3 -> state IDLE, rf_we never asserted, r3 keeps its prior value, all outputs 0.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared opcode and FSM-state definitions for the register-file operation sequencer.
package rf_seq_pkg;

  // Three-bit command opcodes.
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_LDI = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  // Sequencer phases: accept, read operands, execute, write back.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU used in the EXEC phase: result, carry/borrow, zero and write enable.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2:0] op,
  input  logic [N:0] a,
  input  logic [N:0] b,
  input  logic [N:0] imm,
  output logic [N:0] y,
  output logic       c,
  output logic       z,
  output logic       wr_en
);

  logic [N+1:0] w_sum;
  logic [N+1:0] w_dif;

  // One extra bit on each side captures the carry out of ADD and the borrow of SUB.
  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_dif = {1'b0, a} - {1'b0, b};

  // Select the result for the opcode; only ADD and SUB can set the carry flag.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    y = '0;
    c = 1'b0;
    case (op)
      OP_MOV: y = a;
      OP_LDI: y = imm;
      OP_ADD: begin
        y = w_sum[N:0];
        c = w_sum[N+1];
      end
      OP_SUB: begin
        y = w_dif[N:0];
        c = w_dif[N+1];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

  assign z     = (y == '0);
  assign wr_en = (op != OP_NOP);

endmodule

// File: rtl/rf_op_sequencer.sv
// Command sequencer in front of a 3R/1W register file: read two sources, execute, write back.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int M = 3,
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [M:0] cmd_dst,
  input  logic [M:0] cmd_src0,
  input  logic [M:0] cmd_src1,
  input  logic [N:0] cmd_imm,
  output logic [M:0] rf_ra0,
  output logic [M:0] rf_ra1,
  input  logic [N:0] rf_rd0,
  input  logic [N:0] rf_rd1,
  output logic [M:0] rf_wa,
  output logic [N:0] rf_wd,
  output logic       rf_we,
  output logic       done,
  output logic [N:0] result,
  output logic       flag_z,
  output logic       flag_c,
  output logic       busy
);

  state_t     r_state;
  logic [2:0] r_op;
  logic [M:0] r_dst;
  logic [N:0] r_imm;
  logic [N:0] r_opa;
  logic [N:0] r_opb;

  logic [N:0] w_y;
  logic       w_c;
  logic       w_z;
  logic       w_wr_en;

  // Ready depends only on the phase, never on cmd_valid, so no combinational loop can form upstream.
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);

  rf_seq_alu #(
    .N(N)
  ) u_alu (
    .op   (r_op),
    .a    (r_opa),
    .b    (r_opb),
    .imm  (r_imm),
    .y    (w_y),
    .c    (w_c),
    .z    (w_z),
    .wr_en(w_wr_en)
  );

  // Sequencer FSM with all externally visible outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    if (!rst_n) begin
      // Reset drops any in-flight command; since rf_we is cleared here, no write can follow.
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_dst   <= '0;
      r_imm   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      rf_ra0  <= '0;
      rf_ra1  <= '0;
      rf_wa   <= '0;
      rf_wd   <= '0;
      rf_we   <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      // Write enable and done are single-cycle pulses; they default low every edge.
      rf_we <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Capture the whole command now; cmd_* is ignored until the next IDLE.
            r_op    <= cmd_op;
            r_dst   <= cmd_dst;
            r_imm   <= cmd_imm;
            rf_ra0  <= cmd_src0;
            rf_ra1  <= cmd_src1;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          // The file reads combinationally, so the addresses presented this cycle return data now.
          r_opa   <= rf_rd0;
          r_opb   <= rf_rd1;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          // NOP completes without touching the write port, result or flags.
          if (w_wr_en) begin
            rf_wa  <= r_dst;
            rf_wd  <= w_y;
            result <= w_y;
            flag_z <= w_z;
            flag_c <= w_c;
          end
          rf_we   <= w_wr_en;
          done    <= 1'b1;
          r_state <= ST_WB;
        end
        ST_WB: begin
          // The file commits at the end of this cycle, ahead of the next command's READ.
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Randomised scoreboard bench for rf_op_sequencer with a behavioural register file.
module tb_rf_op_sequencer;
  import rf_seq_pkg::*;

  localparam int M = 3;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [M:0] cmd_dst = '0;
  logic [M:0] cmd_src0 = '0;
  logic [M:0] cmd_src1 = '0;
  logic [N:0] cmd_imm = '0;
  logic [M:0] rf_ra0, rf_ra1, rf_wa;
  logic [N:0] rf_rd0, rf_rd1, rf_wd;
  logic       rf_we, done, flag_z, flag_c, busy;
  logic [N:0] result;

  always #5 clk = ~clk;

  rf_op_sequencer #(.M(M), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1),
    .cmd_imm(cmd_imm), .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_rd0(rf_rd0),
    .rf_rd1(rf_rd1), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .done(done),
    .result(result), .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  // Behavioural 3R/1W register file: combinational reads, write on the rising edge.
  logic [N:0] tb_rf [16];
  logic       rf_clear = 1'b1;
  assign rf_rd0 = tb_rf[rf_ra0];
  assign rf_rd1 = tb_rf[rf_ra1];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 16; i++) tb_rf[i] <= '0;
    end else if (rf_we === 1'b1) begin
      tb_rf[rf_wa] <= rf_wd;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and the last result/flags.
  typedef struct packed {
    logic       we;
    logic [M:0] wa;
    logic [N:0] wd;
    logic [N:0] res;
    logic       z;
    logic       c;
  } exp_t;

  exp_t sb_q[$];
  int   m_rf [16];
  int   m_res = 0;
  bit   m_z = 0;
  bit   m_c = 0;

  task automatic model_cmd(input int op, input int d, input int s0, input int s1, input int imm);
    exp_t e;
    int   a, b, y;
    bit   c;
    a = m_rf[s0];
    b = m_rf[s1];
    y = 0;
    c = 0;
    case (op)
      1: y = a;
      2: y = imm;
      3: begin y = (a + b) % 16; c = (a + b) > 15; end
      4: begin y = (a - b + 16) % 16; c = a < b; end
      5: y = a & b;
      6: y = a | b;
      7: y = a ^ b;
      default: y = 0;
    endcase
    if (op != 0) begin
      m_rf[d] = y;
      m_res   = y;
      m_z     = (y == 0);
      m_c     = c;
    end
    e.we  = (op != 0);
    e.wa  = 4'(d);
    e.wd  = 4'(y);
    e.res = 4'(m_res);
    e.z   = m_z;
    e.c   = m_c;
    sb_q.push_back(e);
  endtask

  task automatic scramble();
    cmd_valid = 1'b1;
    cmd_op    = 3'($urandom);
    cmd_dst   = 4'($urandom);
    cmd_src0  = 4'($urandom);
    cmd_src1  = 4'($urandom);
    cmd_imm   = 4'($urandom);
  endtask

  // Present one command at the first IDLE cycle; afterwards keep valid high with junk fields.
  task automatic issue(input int op, input int d, input int s0, input int s1, input int imm,
                       input bit push);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 10) begin
      scramble();
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) check("issue_timeout", guard, 0);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_dst   = 4'(d);
    cmd_src0  = 4'(s0);
    cmd_src1  = 4'(s1);
    cmd_imm   = 4'(imm);
    if (push) model_cmd(op, d, s0, s1, imm);
    @(posedge clk);
    #1;
    scramble();
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 10) begin
      scramble();
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) check("drain_timeout", guard, 0);
    cmd_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks handshake timing.
  bit started    = 0;
  bit reset_test = 0;
  initial begin
    int   run = 0;
    bit   prev_busy = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        if (busy && !prev_busy) begin
          run = 1;
          check("ready_low_after_accept", cmd_ready, 0);
        end else if (busy) begin
          run++;
        end
        if (!busy && prev_busy) begin
          check("ready_high_after_wb", cmd_ready, 1);
          if (!reset_test) check("busy_len", run, 3);
        end
        if (rf_we) check("we_only_with_done", done, 1);
        if (done) begin
          check("done_in_wb", run, 3);
          if (sb_q.size() == 0) begin
            check("sb_pending", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            check("rf_we", rf_we, e.we);
            if (e.we) begin
              check("rf_wa", rf_wa, e.wa);
              check("rf_wd", rf_wd, e.wd);
            end
            check("result", result, e.res);
            check("flag_z", flag_z, e.z);
            check("flag_c", flag_c, e.c);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_we"},    rf_we, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_res"},   result, 0);
    check({tag, "_z"},     flag_z, 0);
    check({tag, "_c"},     flag_c, 0);
    check({tag, "_wa"},    rf_wa, 0);
    check({tag, "_wd"},    rf_wd, 0);
    check({tag, "_ra0"},   rf_ra0, 0);
    check({tag, "_ra1"},   rf_ra1, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n    = 1'b1;
    rf_clear = 1'b0;
    started  = 1;

    // Loads and an overflowing add.
    issue(OP_LDI, 1, 0, 0, 9, 1);
    issue(OP_LDI, 2, 0, 0, 8, 1);
    issue(OP_ADD, 3, 1, 2, 0, 1);
    drain();
    check("t1_r3", tb_rf[3], 1);
    check("t1_c", flag_c, 1);
    check("t1_z", flag_z, 0);

    // Subtraction with and without borrow.
    issue(OP_SUB, 4, 2, 1, 0, 1);
    drain();
    check("t2_r4", tb_rf[4], 15);
    check("t2_c_borrow", flag_c, 1);
    issue(OP_SUB, 5, 1, 2, 0, 1);
    drain();
    check("t2_r5", tb_rf[5], 1);
    check("t2_c_noborrow", flag_c, 0);

    // Zero result, then a NOP that must leave the flags alone.
    issue(OP_XOR, 6, 1, 1, 0, 1);
    issue(OP_NOP, 9, 1, 2, 5, 1);
    drain();
    check("t3_r6", tb_rf[6], 0);
    check("t3_z_after_nop", flag_z, 1);
    check("t3_c_after_nop", flag_c, 0);
    check("t3_r9_untouched", tb_rf[9], 0);

    // Destination equal to source, then a dependent read.
    issue(OP_ADD, 1, 1, 1, 0, 1);
    drain();
    check("t4_r1", tb_rf[1], 2);
    check("t4_c", flag_c, 1);
    issue(OP_MOV, 7, 1, 0, 0, 1);
    drain();
    check("t4_r7", tb_rf[7], 2);

    // Random traffic with busy-time junk on the command bus.
    for (int k = 0; k < 80; k++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15), 1);
    end
    drain();

    // Reset during EXEC: the command must vanish without a write.
    reset_test = 1;
    issue(OP_ADD, 3, 1, 2, 0, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("exec_rst");
    m_res = 0;
    m_z   = 0;
    m_c   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("exec_rst_no_we", rf_we, 0);
    end
    check("exec_rst_r3_kept", tb_rf[3], m_rf[3]);
    reset_test = 0;

    // Recovery after reset.
    for (int k = 0; k < 8; k++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15), 1);
    end
    drain();
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) check($sformatf("final_r%0d", i), tb_rf[i], m_rf[i]);
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
